// File: rtl/execute_cc_stage.sv
// execute_cc_stage
//
// Y86-style pipeline execute stage. Computes valE and the branch/cmov
// condition, holds the {ZF,SF,OF} condition-code register, and owns the
// E->M pipeline register. Optionally contains an iterative shift-add
// multiplier for OPq ifun 4 that stalls upstream while it works.
//
// Build option: define EXEC_MUL_EN to include the multiplier. Without it,
// OPq ifun 4 is an illegal instruction and e_stall is tied low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   E_stat/E_icode/E_ifun    instruction status and code from the E register
//   E_valA/E_valB/E_valC     operands
//   E_dstE/E_dstM            destination registers (0xF = none)
//   m_exc                    later stage holds an exception; blocks CC writes
//   M_stall/M_bubble         M register hold / bubble insert (stall wins)
//   e_stall                  execute busy, upstream must hold E
//   e_valE/e_dstE/e_cnd      combinational results for forwarding
//   cc                       condition codes {ZF,SF,OF}
//   M_*                      registered E->M outputs
module execute_cc_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic             m_exc,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic             e_stall,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_cnd,
  output logic [2:0]       cc,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [WIDTH-1:0] EIGHT = WIDTH'(8);

  logic             mul_legal;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_val;
  logic             alu_of;
  logic             op_illegal;
  logic             cond_true;
  logic             cc_we;

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  mul_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic             mul_req;

  assign mul_req = (E_icode == I_OPQ) && (E_ifun == 4'd4) && (E_stat == STAT_AOK);

  // Multiplier state and datapath. Operands are captured when leaving IDLE
  // so the BUSY iterations never depend on the E inputs. Only the low WIDTH
  // bits of the product are kept, so the multiplicand simply shifts left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        MUL_IDLE: begin
          if (mul_req) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= E_valB;
            mplier_q <= E_valA;
          end
        end
        MUL_BUSY: begin
          acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Next state and stall. DONE waits for the M register to accept the result.
  always_comb begin
    state_d = state_q;
    e_stall = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (mul_req) begin
          e_stall = 1'b1;
          state_d = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        e_stall = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        if (!M_stall) state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  assign mul_legal   = 1'b1;
  assign mul_done    = (state_q == MUL_DONE);
  assign mul_product = acc_q;
`else
  assign mul_legal   = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign e_stall     = 1'b0;
`endif

  // ALU. Overflow is only meaningful for add/sub; every other op leaves OF=0.
  always_comb begin
    alu_val    = '0;
    alu_of     = 1'b0;
    op_illegal = 1'b0;
    case (E_icode)
      I_CMOV:           alu_val = E_valA;
      I_IRMOV:          alu_val = E_valC;
      I_RMMOV, I_MRMOV: alu_val = E_valB + E_valC;
      I_CALL, I_PUSH:   alu_val = E_valB - EIGHT;
      I_RET, I_POP:     alu_val = E_valB + EIGHT;
      I_OPQ: begin
        case (E_ifun)
          4'd0: begin
            alu_val = E_valB + E_valA;
            alu_of  = (E_valA[WIDTH-1] == E_valB[WIDTH-1]) &&
                      (alu_val[WIDTH-1] != E_valA[WIDTH-1]);
          end
          4'd1: begin
            alu_val = E_valB - E_valA;
            alu_of  = (E_valA[WIDTH-1] != E_valB[WIDTH-1]) &&
                      (alu_val[WIDTH-1] != E_valB[WIDTH-1]);
          end
          4'd2: alu_val = E_valB & E_valA;
          4'd3: alu_val = E_valB ^ E_valA;
          4'd4: begin
            if (mul_legal) alu_val = mul_done ? mul_product : '0;
            else           op_illegal = 1'b1;
          end
          default: op_illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  // Branch/cmov condition evaluated against the current CC register.
  always_comb begin
    cond_true = 1'b0;
    case (E_ifun)
      4'd0: cond_true = 1'b1;
      4'd1: cond_true = (cc[1] ^ cc[0]) | cc[2];
      4'd2: cond_true = cc[1] ^ cc[0];
      4'd3: cond_true = cc[2];
      4'd4: cond_true = ~cc[2];
      4'd5: cond_true = ~(cc[1] ^ cc[0]);
      4'd6: cond_true = ~(cc[1] ^ cc[0]) & ~cc[2];
      default: cond_true = 1'b0;
    endcase
  end

  assign e_cnd  = ((E_icode == I_CMOV) || (E_icode == I_JXX)) ? cond_true : 1'b0;
  assign e_valE = alu_val;
  assign e_dstE = (op_illegal || ((E_icode == I_CMOV) && !e_cnd)) ? REG_NONE : E_dstE;

  // CC only commits for a legal OPq that actually leaves execute this edge
  // and is not younger than an exception further down the pipe.
  assign cc_we = (E_icode == I_OPQ) && !op_illegal && (E_stat == STAT_AOK) &&
                 !m_exc && !e_stall && !M_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc <= 3'b100;
    end else if (cc_we) begin
      cc <= {(alu_val == '0), alu_val[WIDTH-1], alu_of};
    end
  end

  // E->M register. A stalled execute stage sends bubbles downstream, and a
  // held M register takes priority over any bubble request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= REG_NONE;
      M_dstM  <= REG_NONE;
    end else if (!M_stall) begin
      if (M_bubble || e_stall) begin
        M_stat  <= STAT_AOK;
        M_icode <= I_NOP;
        M_cnd   <= 1'b0;
        M_valE  <= '0;
        M_valA  <= '0;
        M_dstE  <= REG_NONE;
        M_dstM  <= REG_NONE;
      end else begin
        M_stat  <= op_illegal ? STAT_INS : E_stat;
        M_icode <= E_icode;
        M_cnd   <= e_cnd;
        M_valE  <= e_valE;
        M_valA  <= E_valA;
        M_dstE  <= e_dstE;
        M_dstM  <= E_dstM;
      end
    end
  end

endmodule

// File: tb/tb_execute_cc_stage.sv
// tb_execute_cc_stage
//
// Scoreboard bench for execute_cc_stage. The driver issues one instruction at
// a time, each followed by a bubble cycle, and pushes the reference model's
// expected M contents and CC into a queue. The monitor pops a record each time
// the M register turns from a bubble into a real instruction.
module tb_execute_cc_stage;

  localparam int W = 64;

  typedef struct {
    logic [2:0]   stat;
    logic [3:0]   icode;
    logic         cnd;
    logic [W-1:0] vale;
    logic [W-1:0] vala;
    logic [3:0]   dste;
    logic [3:0]   dstm;
    logic [2:0]   ccv;
    bit           chk_vale;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   E_stat;
  logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM;
  logic [W-1:0] E_valA, E_valB, E_valC;
  logic         m_exc, M_stall, M_bubble;
  logic         e_stall, e_cnd, M_cnd;
  logic [W-1:0] e_valE, M_valE, M_valA;
  logic [3:0]   e_dstE, M_icode, M_dstE, M_dstM;
  logic [2:0]   cc, M_stat;

  int   total = 0;
  int   bad = 0;
  int   n_pushed = 0;
  int   n_seen = 0;
  exp_t sb[$];
  exp_t mon_r;
  logic [3:0] prev_icode = 4'h1;
  logic [2:0] model_cc;

  execute_cc_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_exc(m_exc), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_stall(e_stall), .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd),
    .cc(cc),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction semantics in plain arithmetic. Overflow is
  // the exact signed result disagreeing with the wrapped result.
  task automatic model_exec(input logic [3:0] icode, ifun, input logic [W-1:0] a, b, c,
                            input logic [3:0] dste, dstm, input logic [2:0] stat,
                            input logic mexc, output exp_t r, output logic [2:0] cc_next);
    logic zf, sf, of, taken, legal;
    logic signed [W+1:0] exact;
    logic [W-1:0] res;
    zf = model_cc[2]; sf = model_cc[1]; of = model_cc[0];
    taken = 1'b0;
    if (icode == 4'h2 || icode == 4'h7) begin
      case (ifun)
        4'd0: taken = 1'b1;
        4'd1: taken = (sf != of) || zf;
        4'd2: taken = (sf != of);
        4'd3: taken = zf;
        4'd4: taken = !zf;
        4'd5: taken = (sf == of);
        4'd6: taken = (sf == of) && !zf;
        default: taken = 1'b0;
      endcase
    end
    legal = (ifun <= 4'd3);
`ifdef EXEC_MUL_EN
    if (ifun == 4'd4) legal = 1'b1;
`endif
    res = '0;
    exact = '0;
    case (icode)
      4'h2: res = a;
      4'h3: res = c;
      4'h4, 4'h5: res = b + c;
      4'h8, 4'hA: res = b - 64'd8;
      4'h9, 4'hB: res = b + 64'd8;
      4'h6: begin
        case (ifun)
          4'd0: begin res = b + a; exact = $signed(b) + $signed(a); end
          4'd1: begin res = b - a; exact = $signed(b) - $signed(a); end
          4'd2: res = b & a;
          4'd3: res = b ^ a;
          4'd4: res = b * a;
          default: res = '0;
        endcase
      end
      default: res = '0;
    endcase
    if (!(icode == 4'h6 && (ifun == 4'd0 || ifun == 4'd1))) exact = $signed(res);
    cc_next = model_cc;
    if (icode == 4'h6 && legal && stat == 3'd1 && !mexc)
      cc_next = {res == '0, res[W-1], exact != $signed(res)};
    r.stat     = (icode == 4'h6 && !legal) ? 3'd4 : stat;
    r.icode    = icode;
    r.cnd      = taken;
    r.vale     = res;
    r.vala     = a;
    r.dste     = ((icode == 4'h6 && !legal) || (icode == 4'h2 && !taken)) ? 4'hF : dste;
    r.dstm     = dstm;
    r.ccv      = cc_next;
    r.chk_vale = !(icode == 4'h6 && !legal);
  endtask

  task automatic applyStimulus(input logic [3:0] icode, ifun, input logic [W-1:0] a, b, c,
                               input logic [3:0] dste, dstm, input logic [2:0] stat,
                               input logic mexc, input int nstall);
    exp_t r;
    logic [2:0] cc_next;
    bit mul_path;
    int n;
    model_exec(icode, ifun, a, b, c, dste, dstm, stat, mexc, r, cc_next);
    E_icode = icode; E_ifun = ifun; E_valA = a; E_valB = b; E_valC = c;
    E_dstE = dste; E_dstM = dstm; E_stat = stat; m_exc = mexc;
    M_stall = 1'b0; M_bubble = 1'b0;
    mul_path = 1'b0;
`ifdef EXEC_MUL_EN
    mul_path = (icode == 4'h6 && ifun == 4'd4 && stat == 3'd1);
`endif
    if (mul_path) begin
      #1;
      n = 0;
      while (e_stall === 1'b1 && n < 4 * W) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput("mul_stall_cycles", n, W + 1);
    end
    for (int k = 0; k < nstall; k++) begin
      M_stall = 1'b1;
      @(posedge clk); #1;
      checkOutput("m_held_bubble", M_icode, 4'h1);
    end
    M_stall = 1'b0;
    #1;
    checkOutput("e_cnd", e_cnd, r.cnd);
    checkOutput("e_dstE", e_dstE, r.dste);
    if (r.chk_vale) checkOutput("e_valE", e_valE, r.vale);
    checkOutput("e_stall_low", e_stall, 1'b0);
    sb.push_back(r);
    n_pushed++;
    model_cc = cc_next;
    @(posedge clk); #1;
    E_icode = 4'h1; E_ifun = 4'h0; E_stat = 3'd1; m_exc = 1'b0;
    M_bubble = 1'b1;
    @(posedge clk); #1;
    M_bubble = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 64'd1;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: a bubble-to-instruction transition in M is one DUT output.
  always @(negedge clk) begin
    if (!rst && M_icode != 4'h1 && prev_icode == 4'h1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_underflow: got output icode 0x%0h expected none", M_icode);
      end else begin
        mon_r = sb.pop_front();
        n_seen++;
        checkOutput("M_stat", M_stat, mon_r.stat);
        checkOutput("M_icode", M_icode, mon_r.icode);
        checkOutput("M_cnd", M_cnd, mon_r.cnd);
        if (mon_r.chk_vale) checkOutput("M_valE", M_valE, mon_r.vale);
        checkOutput("M_valA", M_valA, mon_r.vala);
        checkOutput("M_dstE", M_dstE, mon_r.dste);
        checkOutput("M_dstM", M_dstM, mon_r.dstm);
        checkOutput("cc", cc, mon_r.ccv);
      end
    end
    prev_icode = M_icode;
  end

  initial begin
    logic [3:0] ic, fn;
    rst = 1'b1;
    E_stat = 3'd1; E_icode = 4'h1; E_ifun = 4'h0;
    E_valA = '0; E_valB = '0; E_valC = '0; E_dstE = 4'hF; E_dstM = 4'hF;
    m_exc = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
    model_cc = 3'b100;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_M_stat", M_stat, 3'd1);
    checkOutput("rst_M_icode", M_icode, 4'h1);
    checkOutput("rst_M_cnd", M_cnd, 1'b0);
    checkOutput("rst_M_valE", M_valE, 64'd0);
    checkOutput("rst_M_valA", M_valA, 64'd0);
    checkOutput("rst_M_dstE", M_dstE, 4'hF);
    checkOutput("rst_M_dstM", M_dstM, 4'hF);
    checkOutput("rst_cc", cc, 3'b100);
    checkOutput("rst_e_stall", e_stall, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    applyStimulus(4'h6, 4'd1, 64'd5, 64'd5, 64'd0, 4'h3, 4'hF, 3'd1, 1'b1, 0);
    checkOutput("sub_mexc_cc", cc, 3'b100);
    applyStimulus(4'h6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 4'hF, 3'd1, 1'b0, 0);
    checkOutput("add_ovf_cc", cc, 3'b011);
    checkOutput("add_ovf_valE", M_valE, 64'h0);
    applyStimulus(4'h6, 4'd0, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 4'h2, 4'hF, 3'd1, 1'b0, 1);
    checkOutput("sf_only_cc", cc, 3'b010);
    applyStimulus(4'h2, 4'd2, 64'h1234, 64'd0, 64'd0, 4'h5, 4'hF, 3'd1, 1'b0, 0);
    applyStimulus(4'h6, 4'd0, 64'd1, 64'd0, 64'd0, 4'h2, 4'hF, 3'd1, 1'b0, 0);
    checkOutput("clear_cc", cc, 3'b000);
    applyStimulus(4'h2, 4'd2, 64'h1234, 64'd0, 64'd0, 4'h5, 4'hF, 3'd1, 1'b0, 2);
    applyStimulus(4'h6, 4'd7, 64'd3, 64'd4, 64'd0, 4'h1, 4'hF, 3'd1, 1'b0, 0);
    checkOutput("illegal_cc", cc, 3'b000);

`ifdef EXEC_MUL_EN
    $display("[TB] multiplier cases");
    applyStimulus(4'h6, 4'd4, 64'h0D, 64'h0B, 64'd0, 4'h4, 4'hF, 3'd1, 1'b0, 0);
    applyStimulus(4'h6, 4'd4, 64'h0D, 64'h0B, 64'd0, 4'h4, 4'hF, 3'd1, 1'b0, 3);
    applyStimulus(4'h6, 4'd4, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, 4'h7, 4'hF, 3'd1, 1'b0, 0);
    E_icode = 4'h6; E_ifun = 4'd4; E_valA = 64'h0D; E_valB = 64'h0B; E_stat = 3'd1;
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("busy_before_rst", e_stall, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("abort_e_stall", e_stall, 1'b0);
    checkOutput("abort_M_icode", M_icode, 4'h1);
    checkOutput("abort_M_dstE", M_dstE, 4'hF);
    E_icode = 4'h1; E_ifun = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_cc = 3'b100;
    checkOutput("abort_cc", cc, 3'b100);
    @(posedge clk); #1;
`endif

    $display("[TB] random cases");
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0: ic = 4'h2;
        1: ic = 4'h7;
        2, 3, 4: ic = 4'h6;
        5: ic = 4'h0;
        default: ic = 4'($urandom_range(2, 15));
      endcase
      fn = (ic == 4'h6 || ic == 4'h2 || ic == 4'h7) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
`ifdef EXEC_MUL_EN
      if (ic == 4'h6 && fn == 4'd4) fn = 4'd0;
`endif
      applyStimulus(ic, fn, pick_val(), pick_val(), pick_val(),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 4) == 0) ? 3'($urandom_range(2, 4)) : 3'd1,
                    ($urandom_range(0, 6) == 0), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("records_seen", n_seen, n_pushed);
    checkOutput("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_cc_stage.md
# execute_cc_stage

Parametrised Y86-style pipeline execute stage. It computes valE and the branch/cmov condition, and owns the condition-code register with exception-gated updates. It also owns the E→M pipeline register and an optional iterative multiplier that stalls upstream while busy. It sits between the decode/E register and the memory stage, and supplies combinational forwarding values (e_valE, e_dstE) to decode.

## Interface
Parameters:
- WIDTH, 64, datapath width of valA/valB/valC/valE (≥8).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- E_stat  in  3  status (1 AOK, 2 HLT, 3 ADR, 4 INS)
- E_icode, E_ifun  in  4 each  instruction code/function
- E_valA, E_valB, E_valC  in  WIDTH each  operands
- E_dstE, E_dstM  in  4 each  destination registers (0xF = none)
- m_exc  in  1  memory/writeback stage holds an exception; inhibits CC update
- M_stall  in  1  hold M register
- M_bubble  in  1  load bubble into M register (ignored when M_stall=1)
- e_stall  out  1  execute busy; upstream must hold E
- e_valE  out  WIDTH  combinational ALU result (forwarding)
- e_dstE  out  4  combinational dstE after cmov squash
- e_cnd  out  1  combinational condition
- cc  out  3  {ZF,SF,OF} register
- M_stat out 3; M_icode, M_dstE, M_dstM out 4 each; M_cnd out 1; M_valE, M_valA out WIDTH each: registered E→M outputs

## Operation
- ALU by icode:
  - cmovXX (2): valA+0
  - irmovq (3): valC+0
  - rmmovq/mrmovq (4/5): valB+valC
  - call/push (8/A): valB−8
  - ret/pop (9/B): valB+8
  - all others: valE=0
- OPq (6) ifun: 0 add valB+valA; 1 sub valB−valA; 2 and; 3 xor; 4 mul (macro only). Other ifun → illegal: M_stat=INS, e_dstE=0xF, no CC update.
- Arithmetic modulo 2^WIDTH. ZF = result==0; SF = result[WIDTH-1].
- OF: add = same-sign operands with differing result sign. sub = operands of differing sign, result sign ≠ valB sign. Logical ops and mul: OF=0.
- Condition (jXX 7 / cmovXX 2) by ifun:
  - 0 always
  - 1 le (SF^OF)|ZF
  - 2 l SF^OF
  - 3 e ZF
  - 4 ne ~ZF
  - 5 ge ~(SF^OF)
  - 6 g ~(SF^OF)&~ZF
  - ifun>6 → cnd=0
  - other icodes cnd=0
- e_dstE = 0xF if icode=2 and cnd=0, else E_dstE.
- CC write: legal OPq, E_stat=AOK, m_exc=0, e_stall=0, M_stall=0, on that edge.
- M register loads {E_stat or INS, E_icode, e_cnd, e_valE, E_valA, e_dstE, E_dstM} when e_stall=0 and M_stall=0.
- With M_bubble=1 and M_stall=0, M loads the bubble instead. Bubble = stat AOK, icode 1 (nop), cnd 0, valE/valA 0, dstE/dstM 0xF.
- While e_stall=1 and M_stall=0, M loads the bubble.

## Timing
- Reset (async): cc={1,0,0}; M register = bubble; multiplier FSM IDLE; e_stall=0.
- Non-mul ops: zero extra latency; result in M one edge after E presents it.
- Multiplier FSM states:
  - IDLE: legal mul with E_stat=AOK present → e_stall=1; on the edge go BUSY with cnt=0, latching operands.
  - BUSY: e_stall=1; one shift-add bit per edge; after WIDTH edges go DONE.
  - DONE: e_stall=0, e_valE=low WIDTH bits of product. On the edge with M_stall=0, load M (or bubble if M_bubble) and return IDLE. With M_stall=1, stay in DONE.
- Mul latency: e_stall high for exactly WIDTH+1 cycles (with M_stall=0); product in M at edge WIDTH+2.
- E inputs must be held stable while e_stall=1; the FSM uses the latched operands.
- rst mid-multiply aborts to IDLE; the partial product is discarded.
- M_stall and M_bubble both high: stall wins.

## Configuration
- EXEC_MUL_EN defined: OPq ifun 4 is the iterative multiplier above.
- EXEC_MUL_EN undefined: no FSM or multiplier logic. ifun 4 is illegal (INS), and e_stall is tied 0.

## Test plan
- WIDTH=64, add 0x7FFF_FFFF_FFFF_FFFF+1 → M_valE=0x8000_0000_0000_0000; cc={0,1,1} after edge.
- sub with valA=5, valB=5 and m_exc=1 → M_valE=0, cc unchanged from reset {1,0,0}.
- cmovl (ifun 2) with cc={0,1,0} → e_cnd=1, e_dstE=E_dstE; with cc={0,0,0} → e_dstE=0xF, M_cnd=0.
- EXEC_MUL_EN, WIDTH=8, mul valA=0x0D, valB=0x0B → e_stall high 9 cycles, M_valE=0x8F, cc={0,1,0}. Repeat with M_stall held 3 extra cycles in DONE → result delayed 3 cycles, unchanged.
- Assert rst on BUSY cycle 4 of a mul → e_stall=0, M=bubble (icode 1, dstE 0xF) immediately.
- OPq ifun 7 with E_stat=AOK → M_stat=4, M_dstE=0xF, cc unchanged.
